branch_pred_table: RTL and testbench
====================================

// Module: branch_pred_table
// PURPOSE
//  Direct-mapped branch target/prediction table (BTB) for the 5-stage MIPS core.
//  - Fetch side: answers the per-PC lookup with hit H, prediction P and target tgt_f.
//  - Decode side: carries the fetch-time H/P into decode as Hd/Pd.
//  - Update side: executes the tag/prediction writes (WRt/WRp) issued by the branch unit.
// PARAMETERS
//  ENTRIES  16  table entries; power of two >= 2. IDX_W = log2(ENTRIES), derived locally.
//  PC_W     32  PC and target width
// PORTS
//  clk       in   1     clock, single domain
//  rst_n     in   1     asynchronous, active-low reset
//  pc_f      in   PC_W  fetch-stage PC, lookup address
//  H         out  1     lookup hit: entry valid and tag matches
//  P         out  1     predicted taken (meaningful only when H=1, else 0)
//  tgt_f     out  PC_W  stored target for pc_f (0 when H=0)
//  stall_s1  in   1     hold the IF/ID copy of H/P
//  flush_s1  in   1     squash the IF/ID copy of H/P
//  Hd        out  1     registered H of the instruction now in decode
//  Pd        out  1     registered P of the instruction now in decode
//  pc_d      in   PC_W  decode-stage PC, update address
//  br_tgt_d  in   PC_W  branch target computed in decode
//  C         in   1     actual branch outcome (1 = taken)
//  WRt       in   1     write tag, valid and target for pc_d
//  WRp       in   1     update prediction for pc_d using C
//  clr       in   1     one-cycle pulse: invalidate the whole table
//  busy      out  1     clear sweep in progress
// BEHAVIOUR
//  - Addressing: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Word-aligned PCs only.
//  - Lookup is combinational from the array: H = valid[idx] & (tag match); P = H & pred MSB;
//    tgt_f = H ? target : 0. When busy=1, H, P and tgt_f are forced to 0.
//  - Updates occur on the rising clk edge, at index/tag derived from pc_d:
//    - WRt=1: tag <= tag(pc_d); valid <= 1; target <= br_tgt_d.
//    - WRp=1: prediction is updated from C (see CONFIGURATION).
//    - WRt=1 & WRp=0: prediction is left unchanged.
//  - Same-cycle lookup and update to the same index: the lookup returns the pre-update
//    contents; the new contents are visible on the next cycle. No bypass.
//  - IF/ID register, priority flush > stall:
//    - flush_s1=1: Hd <= 0, Pd <= 0.
//    - else stall_s1=1: hold.
//    - else: Hd <= H, Pd <= P.
//  - Clear FSM, states IDLE and SWEEP:
//    - IDLE: clr=1 -> SWEEP with ptr=0.
//    - SWEEP: valid[ptr] <= 0; ptr++; ptr==ENTRIES-1 -> IDLE.
//    - busy=1 exactly in SWEEP, i.e. ENTRIES cycles.
//    - WRt/WRp are ignored during SWEEP; clr is ignored during SWEEP (no restart).
//  - Reset (asynchronous, any time, including mid-sweep):
//    - all valid=0; predictions = reset value; tags/targets = 0.
//    - Hd=Pd=0; FSM=IDLE; ptr=0; busy=0.
//    - Consequently H=P=0 and tgt_f=0.
// CONFIGURATION
//  BPT_2BIT_EN defined: 2-bit saturating counter per entry.
//    - WRp & WRt (allocate): ctr <= C ? 2'b10 : 2'b01.
//    - WRp only: C=1 -> ctr++ saturating at 11; C=0 -> ctr-- saturating at 00.
//    - P = ctr[1]. Reset value 2'b01.
//  BPT_2BIT_EN undefined: 1-bit predictor per entry.
//    - WRp: pbit <= C. P = pbit. Reset value 0.
// TESTING  (ENTRIES=16)
//  1. Reset release, pc_f=0x40 -> H=0, P=0, tgt_f=0, Hd=Pd=0, busy=0.
//  2. pc_d=0x40, br_tgt_d=0x80, C=1, WRt=WRp=1 for one cycle; then pc_f=0x40 -> H=1, P=1, tgt_f=0x80.
//     Then pc_f=0x80 (same idx, other tag) -> H=0.
//  3. Same-cycle: pc_f=pc_d=0x44, WRt=WRp=1, C=1 -> H=0 that cycle; H=1, P=1 the next cycle.
//  4. After test 2, issue WRp C=1 once (ctr=11), then WRp C=0 on two successive cycles:
//     - 2BIT: P=1 after the first C=0 update, P=0 after the second.
//     - 1-bit: P=0 after the first C=0 update.
//  5. H=1, P=1 at fetch with stall_s1=1 -> Hd/Pd hold; flush_s1=1 together with stall_s1=1 -> Hd=Pd=0 next edge.
//  6. Table filled, clr pulse -> busy=1 for exactly 16 cycles with H=0 throughout and WRt ignored;
//     all entries miss afterwards. Repeat with rst_n low at sweep cycle 5 -> busy=0 immediately and all entries miss.

Source files
------------

// File: rtl/branch_pred_table_if.sv
// Bus bundle for branch_pred_table.
//   master : the pipeline side; drives the fetch PC, the IF/ID stall/flush
//            controls, the decode-side update request and the clear pulse.
//   slave  : the table; returns the fetch lookup (H, P, tgt_f), the decode
//            copy (Hd, Pd) and busy.
// Signals:
//   pc_f, H, P, tgt_f          fetch lookup
//   stall_s1, flush_s1, Hd, Pd IF/ID copy of the lookup result
//   pc_d, br_tgt_d, C, WRt, WRp branch-unit update request
//   clr, busy                  whole-table invalidate
interface branch_pred_table_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_f;
  logic            H;
  logic            P;
  logic [PC_W-1:0] tgt_f;
  logic            stall_s1;
  logic            flush_s1;
  logic            Hd;
  logic            Pd;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] br_tgt_d;
  logic            C;
  logic            WRt;
  logic            WRp;
  logic            clr;
  logic            busy;

  modport master (
    output pc_f, stall_s1, flush_s1, pc_d, br_tgt_d, C, WRt, WRp, clr,
    input  H, P, tgt_f, Hd, Pd, busy
  );

  modport slave (
    input  pc_f, stall_s1, flush_s1, pc_d, br_tgt_d, C, WRt, WRp, clr,
    output H, P, tgt_f, Hd, Pd, busy
  );
endinterface

// File: rtl/branch_pred_table.sv
// branch_pred_table: direct-mapped branch target / prediction table.
//   Fetch : combinational lookup of pc_f -> H (hit), P (taken), tgt_f.
//   Decode: IF/ID copy of H/P as Hd/Pd (flush beats stall).
//   Update: WRt writes tag/valid/target, WRp trains the predictor, both at pc_d.
//   Clear : clr starts a one-entry-per-cycle invalidate sweep; busy is high
//           for ENTRIES cycles and blanks the lookup and ignores updates.
// Ports: clk, rst_n (async, active low), bus (branch_pred_table_if.slave).
// Configuration macro BPT_2BIT_EN: defined -> 2-bit saturating counters
// (reset 01); undefined -> 1-bit last-outcome predictor (reset 0).
module branch_pred_table #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_pred_table_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
`ifdef BPT_2BIT_EN
  localparam int              PRED_W   = 2;
  localparam logic [PRED_W-1:0] PRED_RST = 2'b01;
`else
  localparam int              PRED_W   = 1;
  localparam logic [PRED_W-1:0] PRED_RST = 1'b0;
`endif

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_d  [ENTRIES];
  logic [PC_W-1:0]    tgt_q  [ENTRIES];
  logic [PC_W-1:0]    tgt_d  [ENTRIES];
  logic [PRED_W-1:0]  pred_q [ENTRIES];
  logic [PRED_W-1:0]  pred_d [ENTRIES];
  logic               hd_q, hd_d, pd_q, pd_d;
  logic               busy, hit, pred_taken;

  logic [IDX_W-1:0]   idx_f, idx_u;
  logic [TAG_W-1:0]   tag_f, tag_u;

  assign idx_f = bus.pc_f[IDX_W+1:2];
  assign tag_f = bus.pc_f[PC_W-1:IDX_W+2];
  assign idx_u = bus.pc_d[IDX_W+1:2];
  assign tag_u = bus.pc_d[PC_W-1:IDX_W+2];

  // Lookup reads the registered array only, so a same-cycle update to the
  // same index is seen one cycle later.
  always_comb begin
    hit        = !busy && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken = hit && pred_q[idx_f][PRED_W-1];
  end

  assign bus.H     = hit;
  assign bus.P     = pred_taken;
  assign bus.tgt_f = hit ? tgt_q[idx_f] : '0;
  assign bus.Hd    = hd_q;
  assign bus.Pd    = pd_q;
  assign bus.busy  = busy;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SWEEP);
  end

  // ---------------- table and IF/ID next state ----------------
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    pred_d  = pred_q;
    if (busy) begin
      valid_d[ptr_q] = 1'b0;
    end else begin
      if (bus.WRt) begin
        valid_d[idx_u] = 1'b1;
        tag_d[idx_u]   = tag_u;
        tgt_d[idx_u]   = bus.br_tgt_d;
      end
      if (bus.WRp) begin
`ifdef BPT_2BIT_EN
        if (bus.WRt) begin
          // Fresh allocation starts weakly biased toward the observed outcome.
          pred_d[idx_u] = bus.C ? 2'b10 : 2'b01;
        end else if (bus.C) begin
          if (pred_q[idx_u] != 2'b11) pred_d[idx_u] = pred_q[idx_u] + 2'b01;
        end else begin
          if (pred_q[idx_u] != 2'b00) pred_d[idx_u] = pred_q[idx_u] - 2'b01;
        end
`else
        pred_d[idx_u] = bus.C;
`endif
      end
    end
  end

  always_comb begin
    hd_d = hd_q;
    pd_d = pd_q;
    if (bus.flush_s1) begin
      hd_d = 1'b0;
      pd_d = 1'b0;
    end else if (!bus.stall_s1) begin
      hd_d = hit;
      pd_d = pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table arrays are reset explicitly because the reset state
      // of tags, targets and predictors is architecturally defined here.
      valid_q <= '0;
      hd_q    <= 1'b0;
      pd_q    <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        tgt_q[i]  <= '0;
        pred_q[i] <= PRED_RST;
      end
    end else begin
      valid_q <= valid_d;
      hd_q    <= hd_d;
      pd_q    <= pd_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= tag_d[i];
        tgt_q[i]  <= tgt_d[i];
        pred_q[i] <= pred_d[i];
      end
    end
  end
endmodule

// File: tb/tb_branch_pred_table.sv
// Testbench for branch_pred_table (ENTRIES=16, PC_W=32). A behavioural model
// tracks the table as plain arrays and a countdown for the clear sweep; a
// compare process checks every DUT output against it on each falling edge,
// and directed steps pin the model with hand-computed literals.
module tb_branch_pred_table;
  localparam int ENTRIES = 16;
  localparam int PC_W    = 32;
`ifdef BPT_2BIT_EN
  localparam bit TWO_BIT = 1'b1;
`else
  localparam bit TWO_BIT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_cmp;
  int   n_err;

  branch_pred_table_if #(.PC_W(PC_W)) bif ();

  branch_pred_table #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_hd, m_pd;
  int          m_busy;
  bit          m_h, m_p;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return (m_busy == 0) && m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / (ENTRIES * 4));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    if (!m_hit(pc)) return 1'b0;
    return TWO_BIT ? (m_ctr[m_idx(pc)] >= 2) : (m_ctr[m_idx(pc)] == 1);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = 0;
        m_tgt[i]   = 32'h0;
        m_ctr[i]   = TWO_BIT ? 1 : 0;
      end
      m_hd   = 1'b0;
      m_pd   = 1'b0;
      m_busy = 0;
    end else begin
      m_h = m_hit(bif.pc_f);
      m_p = m_pred(bif.pc_f);
      if (bif.flush_s1) begin
        m_hd = 1'b0;
        m_pd = 1'b0;
      end else if (!bif.stall_s1) begin
        m_hd = m_h;
        m_pd = m_p;
      end
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        if (bif.WRt) begin
          m_valid[m_idx(bif.pc_d)] = 1'b1;
          m_tag[m_idx(bif.pc_d)]   = bif.pc_d / (ENTRIES * 4);
          m_tgt[m_idx(bif.pc_d)]   = bif.br_tgt_d;
        end
        if (bif.WRp) begin
          if (!TWO_BIT)      m_ctr[m_idx(bif.pc_d)] = bif.C ? 1 : 0;
          else if (bif.WRt)  m_ctr[m_idx(bif.pc_d)] = bif.C ? 2 : 1;
          else if (bif.C)    m_ctr[m_idx(bif.pc_d)] = (m_ctr[m_idx(bif.pc_d)] == 3) ? 3 : m_ctr[m_idx(bif.pc_d)] + 1;
          else               m_ctr[m_idx(bif.pc_d)] = (m_ctr[m_idx(bif.pc_d)] == 0) ? 0 : m_ctr[m_idx(bif.pc_d)] - 1;
        end
        // The whole table reads as empty for the entire sweep and after it.
        if (bif.clr) begin
          for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
          m_busy = ENTRIES;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_H",     32'(bif.H),  32'(m_hit(bif.pc_f)));
      check("cmp_P",     32'(bif.P),  32'(m_pred(bif.pc_f)));
      check("cmp_tgt_f", bif.tgt_f,   m_target(bif.pc_f));
      check("cmp_Hd",    32'(bif.Hd), 32'(m_hd));
      check("cmp_Pd",    32'(bif.Pd), 32'(m_pd));
      check("cmp_busy",  32'(bif.busy), 32'(m_busy > 0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_table();
    for (int i = 0; i < ENTRIES; i++) begin
      bif.pc_d     = 32'(i * 4);
      bif.br_tgt_d = 32'h1000 + 32'(i * 4);
      bif.C        = i[0];
      bif.WRt      = 1'b1;
      bif.WRp      = 1'b1;
      cyc();
    end
    bif.WRt = 1'b0;
    bif.WRp = 1'b0;
  endtask

  task automatic all_miss(input string name);
    for (int i = 0; i < ENTRIES; i++) begin
      bif.pc_f = 32'(i * 4);
      #1;
      check(name, 32'(bif.H), 32'h0);
    end
  endtask

  initial begin
    int n_busy;
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_busy;
    n_cmp = 0;
    n_err = 0;
    chk_en = 1'b0;
    rst_n = 1'b1;
    bif.pc_f = '0; bif.stall_s1 = 0; bif.flush_s1 = 0; bif.pc_d = '0;
    bif.br_tgt_d = '0; bif.C = 0; bif.WRt = 0; bif.WRp = 0; bif.clr = 0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1. reset state
    bif.pc_f = 32'h40;
    #1;
    check("rst_H", 32'(bif.H), 0);
    check("rst_P", 32'(bif.P), 0);
    check("rst_tgt_f", bif.tgt_f, 0);
    check("rst_Hd", 32'(bif.Hd), 0);
    check("rst_Pd", 32'(bif.Pd), 0);
    check("rst_busy", 32'(bif.busy), 0);

    // 2. allocate 0x40 -> 0x80, taken
    bif.pc_d = 32'h40; bif.br_tgt_d = 32'h80; bif.C = 1; bif.WRt = 1; bif.WRp = 1;
    cyc();
    bif.WRt = 0; bif.WRp = 0;
    #1;
    check("alloc_H", 32'(bif.H), 1);
    check("alloc_P", 32'(bif.P), 1);
    check("alloc_tgt_f", bif.tgt_f, 32'h80);
    bif.pc_f = 32'h80;
    #1;
    check("alias_miss_H", 32'(bif.H), 0);
    check("alias_miss_tgt_f", bif.tgt_f, 0);

    // 3. same-cycle lookup and update, no bypass
    bif.pc_f = 32'h44; bif.pc_d = 32'h44; bif.br_tgt_d = 32'h100; bif.C = 1;
    bif.WRt = 1; bif.WRp = 1;
    #1;
    check("same_cycle_H", 32'(bif.H), 0);
    cyc();
    bif.WRt = 0; bif.WRp = 0;
    #1;
    check("next_cycle_H", 32'(bif.H), 1);
    check("next_cycle_P", 32'(bif.P), 1);
    check("next_cycle_tgt", bif.tgt_f, 32'h100);

    // 4. predictor training at 0x40
    bif.pc_d = 32'h40; bif.WRp = 1; bif.C = 1; bif.pc_f = 32'h40;
    cyc();
    bif.C = 0;
    cyc();
    #1;
    check("train_first_not_taken_P", 32'(bif.P), TWO_BIT ? 1 : 0);
    cyc();
    bif.WRp = 0;
    #1;
    check("train_second_not_taken_P", 32'(bif.P), 0);
    check("train_still_hit_H", 32'(bif.H), 1);

    // 5. IF/ID stall and flush
    bif.WRp = 1; bif.C = 1;
    cyc();
    cyc();
    bif.WRp = 0;
    bif.pc_f = 32'h80;
    cyc();
    bif.pc_f = 32'h40; bif.stall_s1 = 1;
    #1;
    check("stall_src_H", 32'(bif.H), 1);
    check("stall_src_P", 32'(bif.P), 1);
    cyc();
    #1;
    check("stall_hold_Hd", 32'(bif.Hd), 0);
    bif.stall_s1 = 0;
    cyc();
    #1;
    check("pass_Hd", 32'(bif.Hd), 1);
    check("pass_Pd", 32'(bif.Pd), 1);
    bif.pc_f = 32'h80; bif.stall_s1 = 1;
    cyc();
    #1;
    check("stall_hold_Hd1", 32'(bif.Hd), 1);
    check("stall_hold_Pd1", 32'(bif.Pd), 1);
    bif.pc_f = 32'h40; bif.flush_s1 = 1;
    cyc();
    #1;
    check("flush_Hd", 32'(bif.Hd), 0);
    check("flush_Pd", 32'(bif.Pd), 0);
    bif.flush_s1 = 0; bif.stall_s1 = 0;

    // 6a. full sweep with WRt attempted throughout
    fill_table();
    bif.pc_f = 32'h14;
    #1;
    check("filled_H", 32'(bif.H), 1);
    check("filled_tgt", bif.tgt_f, 32'h1014);
    bif.clr = 1;
    cyc();
    bif.clr = 0;
    bif.pc_d = 32'h8; bif.br_tgt_d = 32'hdead0; bif.WRt = 1;
    n_busy = 0;
    while (bif.busy && n_busy < 40) begin
      bif.pc_f = 32'((n_busy % ENTRIES) * 4);
      #1;
      check("sweep_H", 32'(bif.H), 0);
      n_busy++;
      cyc();
    end
    bif.WRt = 0;
    check("sweep_busy_cycles", 32'(n_busy), 16);
    all_miss("after_sweep_H");

    // 6b. reset in the middle of a sweep
    fill_table();
    bif.clr = 1;
    cyc();
    bif.clr = 0;
    repeat (5) cyc();
    #1;
    check("midsweep_busy_before", 32'(bif.busy), 1);
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_busy", 32'(bif.busy), 0);
    check("midsweep_rst_H", 32'(bif.H), 0);
    cyc();
    rst_n = 1'b1;
    all_miss("after_rst_H");
    cyc();
    #1;
    check("after_rst_busy", 32'(bif.busy), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
